// File: rtl/pipeline_bypass_mux.sv
// ============================================================================
// Module   : pipeline_bypass_mux
// Purpose  : Build-time selectable single-stage pipeline register or
//            zero-latency combinational bypass. Defining PIPELINE_MUX_VALID_EN
//            adds an out_valid port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_bypass_mux #(
    parameter int    WIDTH           = 4,
    parameter int    PIPELINE_ENABLE = 1,
    parameter string RSTTYPE         = "SYNC"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
`ifdef PIPELINE_MUX_VALID_EN
    ,
    output logic             out_valid
`endif
);

    generate
        if (RSTTYPE != "SYNC") begin : g_bad_rsttype
            $error("pipeline_bypass_mux: only RSTTYPE \"SYNC\" is supported");
        end

        if (PIPELINE_ENABLE == 0) begin : g_bypass
            // Control inputs are intentionally ignored on the bypass path.
            logic w_unused_ctrl;
            assign w_unused_ctrl = clk ^ rst ^ en;
            assign out           = in;
`ifdef PIPELINE_MUX_VALID_EN
            assign out_valid     = 1'b1;
`endif
        end else begin : g_pipe
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (en) begin
                    r_q <= in;
                end
            end

            assign out = r_q;

`ifdef PIPELINE_MUX_VALID_EN
            // Sticky flag: set by the first enabled load after reset.
            logic r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                end else if (en) begin
                    r_valid <= 1'b1;
                end
            end

            assign out_valid = r_valid;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipeline_bypass_mux.sv
// ============================================================================
// Module   : tb_pipeline_bypass_mux
// Purpose  : Scoreboard bench for the registered and bypass builds side by side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_bypass_mux;

    localparam int c_width = 4;

    logic               clk;
    logic               rst_r, en_r, rst_b, en_b;
    logic [c_width-1:0] in_r, in_b;
    logic [c_width-1:0] out_r, out_b;
`ifdef PIPELINE_MUX_VALID_EN
    logic               out_valid_r, out_valid_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [c_width-1:0] sb_data[$];
    logic               sb_valid[$];

    // Reference model state for the registered instance
    logic [c_width-1:0] m_q = 'x;
    logic               m_v = 1'bx;

    pipeline_bypass_mux #(.WIDTH(c_width), .PIPELINE_ENABLE(1), .RSTTYPE("SYNC")) u_dut_reg (
        .clk       (clk),
        .rst       (rst_r),
        .en        (en_r),
        .in        (in_r),
        .out       (out_r)
`ifdef PIPELINE_MUX_VALID_EN
        ,
        .out_valid (out_valid_r)
`endif
    );

    pipeline_bypass_mux #(.WIDTH(c_width), .PIPELINE_ENABLE(0), .RSTTYPE("SYNC")) u_dut_byp (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
        .in        (in_b),
        .out       (out_b)
`ifdef PIPELINE_MUX_VALID_EN
        ,
        .out_valid (out_valid_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One clock of the registered instance: drive at negedge, verify the output
    // has not moved before the edge, then verify the popped expectation after it.
    task automatic step(input string tag, input logic r, input logic e, input logic [c_width-1:0] d);
        logic [c_width-1:0] exp_d;
        logic               exp_v;
        @(negedge clk);
        rst_r = r;
        en_r  = e;
        in_r  = d;
        #1;
        check_value({tag, "_pre"}, {4'h0, out_r}, {4'h0, m_q});
        if (r) begin
            m_q = '0;
            m_v = 1'b0;
        end else if (e) begin
            m_q = d;
            m_v = 1'b1;
        end
        sb_data.push_back(m_q);
        sb_valid.push_back(m_v);
        @(posedge clk);
        #1;
        exp_d = sb_data.pop_front();
        exp_v = sb_valid.pop_front();
        check_value(tag, {4'h0, out_r}, {4'h0, exp_d});
`ifdef PIPELINE_MUX_VALID_EN
        check_value({tag, "_valid"}, {7'h0, out_valid_r}, {7'h0, exp_v});
`else
        if (exp_v === 1'b0) exp_v = 1'b0;
`endif
    endtask

    initial begin
        logic [c_width-1:0] exp_b;
        rst_r = 1'b1; en_r = 1'b0; in_r = '0;
        rst_b = 1'b1; en_b = 1'b0; in_b = '0;

        // ---------------- bypass instance ----------------
        #1;
        in_b = 4'hA;
        sb_data.push_back(in_b);
        #1;
        exp_b = sb_data.pop_front();
        check_value("byp_in_rst", {4'h0, out_b}, {4'h0, exp_b});
`ifdef PIPELINE_MUX_VALID_EN
        check_value("byp_valid", {7'h0, out_valid_b}, 8'h01);
`endif
        for (int i = 0; i < 100; i++) begin
            in_b  = c_width'($urandom_range(0, 15));
            en_b  = 1'($urandom_range(0, 1));
            rst_b = 1'($urandom_range(0, 1));
            sb_data.push_back(in_b);
            #1;
            exp_b = sb_data.pop_front();
            check_value("byp_stream", {4'h0, out_b}, {4'h0, exp_b});
            #1;
        end

        // ---------------- registered instance ----------------
        step("reg_reset",   1'b1, 1'b0, 4'h0);
        step("reg_en0_rst", 1'b0, 1'b0, 4'h7);
        step("reg_load5",   1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 3; i++) step("reg_hold", 1'b0, 1'b0, 4'hC);
        step("reg_loadC",   1'b0, 1'b1, 4'hC);
        step("reg_rst_pri", 1'b1, 1'b1, 4'hF);
        step("reg_load9",   1'b0, 1'b1, 4'h9);

        // Reset pulse strictly between edges must not disturb the register
        @(negedge clk);
        en_r  = 1'b0;
        rst_r = 1'b1;
        #2;
        check_value("reg_rst_pulse", {4'h0, out_r}, {4'h0, m_q});
        rst_r = 1'b0;
        step("reg_after_pulse", 1'b0, 1'b0, 4'h3);

        for (int i = 1; i <= 4; i++) step("reg_stream", 1'b0, 1'b1, c_width'(i));

        for (int i = 0; i < 30; i++)
            step("reg_rand", 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 c_width'($urandom_range(0, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
